// File: rtl/speck_encrypt_ecb_iter_pkg.sv
// Shared settings for the SPECK encrypt core: FSM encoding, default rotations, round counts.
// The optional debug ports are enabled with the SPECK_ENCRYPT_DEBUG_EN macro.
package speck_encrypt_ecb_iter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRound = 2'd1,
      StDone  = 2'd2
   } state_e;

   localparam int unsigned DefaultAlpha = 8;
   localparam int unsigned DefaultBeta  = 3;

   function automatic int unsigned nr_rounds(input int unsigned block_size,
                                             input int unsigned key_size);
      int unsigned n;
      n = 27;
      if (block_size == 64 && key_size == 96) n = 26;
      if (block_size == 64 && key_size == 128) n = 27;
      if (block_size == 128 && key_size == 128) n = 32;
      if (block_size == 128 && key_size == 192) n = 33;
      if (block_size == 128 && key_size == 256) n = 34;
      return n;
   endfunction

endpackage

// File: rtl/speck_enc_round.sv
// One SPECK encryption round plus the matching key-schedule step, purely combinational.
module speck_enc_round #(
   parameter int unsigned WORD  = 32,
   parameter int unsigned ALPHA = 8,
   parameter int unsigned BETA  = 3
) (
   input  logic [WORD-1:0] x,
   input  logic [WORD-1:0] y,
   input  logic [WORD-1:0] k,
   input  logic [WORD-1:0] l0,
   input  logic [WORD-1:0] rnd,
   output logic [WORD-1:0] x_next,
   output logic [WORD-1:0] y_next,
   output logic [WORD-1:0] k_next,
   output logic [WORD-1:0] l_new
);

   logic [WORD-1:0] x_ror;
   logic [WORD-1:0] y_rol;
   logic [WORD-1:0] l0_ror;
   logic [WORD-1:0] k_rol;

   assign x_ror  = (x >> ALPHA) | (x << (WORD - ALPHA));
   assign y_rol  = (y << BETA) | (y >> (WORD - BETA));
   assign l0_ror = (l0 >> ALPHA) | (l0 << (WORD - ALPHA));
   assign k_rol  = (k << BETA) | (k >> (WORD - BETA));

   assign x_next = (x_ror + y) ^ k;
   assign y_next = y_rol ^ x_next;

   // The key schedule is the round function itself with the round index as key.
   assign l_new  = (k + l0_ror) ^ rnd;
   assign k_next = k_rol ^ l_new;

endmodule

// File: rtl/speck_encrypt_ecb_iter.sv
// Iterative SPECK ECB encryption core: one round per cycle, round keys expanded on the fly.
// Define SPECK_ENCRYPT_DEBUG_EN to expose state_response and round_response.
module speck_encrypt_ecb_iter
   import speck_encrypt_ecb_iter_pkg::*;
#(
   parameter int unsigned BLOCK_SIZE = 64,
   parameter int unsigned KEY_SIZE   = 128,
   parameter int unsigned NR_ROUNDS  = nr_rounds(BLOCK_SIZE, KEY_SIZE),
   parameter int unsigned ALPHA      = DefaultAlpha,
   parameter int unsigned BETA       = DefaultBeta
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BLOCK_SIZE-1:0] plaintext,
   input  logic [KEY_SIZE-1:0]   key,
   output logic [BLOCK_SIZE-1:0] ciphertext,
   output logic                  active,
   output logic                  ready
`ifdef SPECK_ENCRYPT_DEBUG_EN
   ,
   output logic [3:0]            state_response,
   output logic [7:0]            round_response
`endif
);

   localparam int unsigned WORD = BLOCK_SIZE / 2;
   localparam int unsigned M    = KEY_SIZE / WORD;

   state_e                    state_q, state_d;
   logic [WORD-1:0]           x_q, x_d;
   logic [WORD-1:0]           y_q, y_d;
   logic [WORD-1:0]           k_q, k_d;
   logic [M-2:0][WORD-1:0]    l_q, l_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [BLOCK_SIZE-1:0]     ct_q, ct_d;
   logic                      active_q, active_d;
   logic                      ready_q, ready_d;

   logic [WORD-1:0]           x_nx, y_nx, k_nx, l_new, rnd_ext;

   assign rnd_ext = {{(WORD - 8){1'b0}}, cnt_q};

   speck_enc_round #(
      .WORD  (WORD),
      .ALPHA (ALPHA),
      .BETA  (BETA)
   ) u_round (
      .x      (x_q),
      .y      (y_q),
      .k      (k_q),
      .l0     (l_q[0]),
      .rnd    (rnd_ext),
      .x_next (x_nx),
      .y_next (y_nx),
      .k_next (k_nx),
      .l_new  (l_new)
   );

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      k_d      = k_q;
      l_d      = l_q;
      cnt_d    = cnt_q;
      ct_d     = ct_q;
      active_d = active_q;
      ready_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               x_d      = plaintext[BLOCK_SIZE-1:WORD];
               y_d      = plaintext[WORD-1:0];
               k_d      = key[WORD-1:0];
               l_d      = key[KEY_SIZE-1:WORD];
               cnt_d    = '0;
               active_d = 1'b1;
               state_d  = StRound;
            end else begin
               active_d = 1'b0;
            end
         end
         StRound: begin
            x_d = x_nx;
            y_d = y_nx;
            k_d = k_nx;
            // l acts as a shift register feeding l[0] into the next key step.
            for (int j = 0; j < int'(M) - 2; j++) begin
               l_d[j] = l_q[j+1];
            end
            l_d[M-2] = l_new;
            if (cnt_q == 8'(NR_ROUNDS - 1)) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDone: begin
            ct_d     = {x_q, y_q};
            ready_d  = 1'b1;
            active_d = 1'b0;
            state_d  = StIdle;
         end
         default: begin
            state_d  = StIdle;
            ct_d     = '0;
            active_d = 1'b0;
            ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         x_q      <= '0;
         y_q      <= '0;
         k_q      <= '0;
         l_q      <= '0;
         cnt_q    <= '0;
         ct_q     <= '0;
         active_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         k_q      <= k_d;
         l_q      <= l_d;
         cnt_q    <= cnt_d;
         ct_q     <= ct_d;
         active_q <= active_d;
         ready_q  <= ready_d;
      end
   end

   assign ciphertext = ct_q;
   assign active     = active_q;
   assign ready      = ready_q;

`ifdef SPECK_ENCRYPT_DEBUG_EN
   assign state_response = {2'b00, state_q};
   assign round_response = cnt_q;
`endif

endmodule

// File: tb/tb_speck_encrypt_ecb_iter.sv
// Scoreboard bench for speck_encrypt_ecb_iter: stimulus pushes expected results, a monitor checks.
module tb_speck_encrypt_ecb_iter;

   localparam logic [127:0] KeyV = 128'h1b1a1918_13121110_0b0a0908_03020100;
   localparam logic [63:0]  PtV  = 64'h3b726574_7475432d;
   localparam logic [63:0]  CtV  = 64'h8c6fa548_454e028b;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [63:0]  plaintext;
   logic [127:0] key;
   logic [63:0]  ciphertext;
   logic         active;
   logic         ready;
`ifdef SPECK_ENCRYPT_DEBUG_EN
   logic [3:0]   state_response;
   logic [7:0]   round_response;
`endif

   speck_encrypt_ecb_iter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .plaintext      (plaintext),
      .key            (key),
      .ciphertext     (ciphertext),
      .active         (active),
      .ready          (ready)
`ifdef SPECK_ENCRYPT_DEBUG_EN
      ,
      .state_response (state_response),
      .round_response (round_response)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] ct;
      int unsigned at;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   logic ready_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ror8(input logic [31:0] v);
      return {v[7:0], v[31:8]};
   endfunction

   function automatic logic [31:0] rol3(input logic [31:0] v);
      return {v[28:0], v[31:29]};
   endfunction

   // Textbook SPECK64/128: expand the whole key schedule first, then encrypt.
   function automatic logic [63:0] speck_ref(input logic [63:0] pt, input logic [127:0] k);
      logic [31:0] ks[27];
      logic [31:0] l[30];
      logic [31:0] x, y;
      ks[0] = k[31:0];
      l[0]  = k[63:32];
      l[1]  = k[95:64];
      l[2]  = k[127:96];
      for (int i = 0; i < 26; i++) begin
         l[i+3]  = (ks[i] + ror8(l[i])) ^ 32'(i);
         ks[i+1] = rol3(ks[i]) ^ l[i+3];
      end
      x = pt[63:32];
      y = pt[31:0];
      for (int i = 0; i < 27; i++) begin
         x = (ror8(x) + y) ^ ks[i];
         y = rol3(y) ^ x;
      end
      return {x, y};
   endfunction

   // Monitor: every ready pulse must match the oldest expectation, in value and timing.
   always @(negedge clk) begin
      if (ready) begin
         check("ready_one_cycle", {63'b0, ready_prev}, 64'd0);
         if (sb.size() == 0) begin
            check("spurious_ready", {63'b0, ready}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("ciphertext", ciphertext, e.ct);
            check("ready_cycle", 64'(cyc), 64'(e.at));
         end
      end
      ready_prev = ready;
   end

   task automatic issue(input logic [63:0] pt, input logic [127:0] k, input logic push);
      exp_t e;
      @(negedge clk);
      plaintext = pt;
      key       = k;
      start     = 1'b1;
      if (push) begin
         e.ct = speck_ref(pt, k);
         e.at = cyc + 1 + 28;
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
      check(name, 64'(sb.size()), 64'd0);
   endtask

   logic [63:0] acc;

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      plaintext = '0;
      key       = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ciphertext", ciphertext, 64'd0);
      check("reset_active", {63'b0, active}, 64'd0);
      check("reset_ready", {63'b0, ready}, 64'd0);
      rst_n = 1'b1;

      // Idle: nothing should move without start.
      acc = '0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         acc = acc | ciphertext | {62'b0, active, ready};
      end
      check("idle_outputs", acc, 64'd0);

      // Vector check with per-round activity tracking.
      issue(PtV, KeyV, 1'b0);
      sb.push_back('{ct: CtV, at: cyc + 1 + 28});
      @(negedge clk);
      start = 1'b0;
      for (int r = 0; r < 27; r++) begin
         check("active_round", {63'b0, active}, 64'd1);
`ifdef SPECK_ENCRYPT_DEBUG_EN
         check("dbg_round", {56'b0, round_response}, 64'(r));
         check("dbg_state_round", {60'b0, state_response}, 64'd1);
`endif
         @(negedge clk);
      end
      check("active_done", {63'b0, active}, 64'd1);
`ifdef SPECK_ENCRYPT_DEBUG_EN
      check("dbg_state_done", {60'b0, state_response}, 64'd2);
`endif
      @(negedge clk);
      check("active_after", {63'b0, active}, 64'd0);
`ifdef SPECK_ENCRYPT_DEBUG_EN
      check("dbg_state_idle", {60'b0, state_response}, 64'd0);
`endif
      drain("drain_vector");

      // Input change and stray start mid-operation must be ignored.
      issue(PtV, KeyV, 1'b1);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      plaintext = {$urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain("drain_midchange");
      repeat (40) @(negedge clk);
      check("no_second_op", {63'b0, active}, 64'd0);

      // Back-to-back with start held high; second block encrypts zero.
      begin
         int unsigned c0;
         issue(PtV, KeyV, 1'b1);
         c0 = cyc;
         sb.push_back('{ct: speck_ref(64'd0, KeyV), at: c0 + 1 + 28 + 29});
         @(negedge clk);
         plaintext = '0;
         while (cyc < c0 + 30) @(negedge clk);
         start = 1'b0;
      end
      drain("drain_b2b");

      // Reset during round 15 discards the operation.
      issue(PtV, KeyV, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midreset_active", {63'b0, active}, 64'd0);
      check("midreset_ready", {63'b0, ready}, 64'd0);
      check("midreset_ciphertext", ciphertext, 64'd0);
      repeat (40) @(negedge clk);
      check("midreset_ct_held", ciphertext, 64'd0);

      // Fresh operation after reset, with a second key pattern.
      issue(PtV, KeyV, 1'b1);
      @(negedge clk);
      start = 1'b0;
      drain("drain_after_reset");
      issue(64'h0123_4567_89ab_cdef, ~KeyV, 1'b1);
      @(negedge clk);
      start = 1'b0;
      drain("drain_alt_key");

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
